// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, keyboard command bytes, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2State_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // PS/2 frames use odd parity over the data byte.
    function automatic logic oddParity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizer for the raw PS/2 clock and data lines, plus synced-clock falling-edge detect.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clkRaw,
    input  logic dataRaw,
    output logic clkSync,
    output logic dataSync,
    output logic clkFall
);

    logic [1:0] clkFf;
    logic [1:0] dataFf;
    logic       clkPrev;

    // Idle bus level is high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clkFf   <= 2'b11;
            dataFf  <= 2'b11;
            clkPrev <= 1'b1;
        end else begin
            clkFf   <= {clkFf[0], clkRaw};
            dataFf  <= {dataFf[0], dataRaw};
            clkPrev <= clkFf[1];
        end
    end

    assign clkSync  = clkFf[1];
    assign dataSync = dataFf[1];
    assign clkFall  = clkPrev & ~clkFf[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; pulls the lines low through output enables only.
// Optional watchdog from clock release to bus idle: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);
    import ps2_pkg::*;

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    ps2State_t      state, stateNxt;
    logic [8:0]     frame, frameNxt;      // {parity, data}
    logic [3:0]     bitCnt, bitCntNxt;
    logic [CW-1:0]  cnt, cntNxt;          // inhibit timer, then watchdog
    logic           clkOe, clkOeNxt, dataOe, dataOeNxt;
    logic           done, doneNxt, err, errNxt;
    logic           clkSync, dataSync, clkFall;

    ps2_line_sync uSync (
        .clk      (clk),
        .rst_n    (rst_n),
        .clkRaw   (ps2_clk_in),
        .dataRaw  (ps2_data_in),
        .clkSync  (clkSync),
        .dataSync (dataSync),
        .clkFall  (clkFall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            frame  <= '0;
            bitCnt <= '0;
            cnt    <= '0;
            clkOe  <= 1'b0;
            dataOe <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= stateNxt;
            frame  <= frameNxt;
            bitCnt <= bitCntNxt;
            cnt    <= cntNxt;
            clkOe  <= clkOeNxt;
            dataOe <= dataOeNxt;
            done   <= doneNxt;
            err    <= errNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        frameNxt  = frame;
        bitCntNxt = bitCnt;
        cntNxt    = cnt;
        clkOeNxt  = clkOe;
        dataOeNxt = dataOe;
        doneNxt   = 1'b0;
        errNxt    = 1'b0;
        case (state)
            IDLE: begin
                cntNxt    = '0;
                bitCntNxt = '0;
                clkOeNxt  = 1'b0;
                dataOeNxt = 1'b0;
                if (tx_valid) begin
                    frameNxt = {oddParity(tx_data), tx_data};
                    clkOeNxt = 1'b1;
                    stateNxt = INHIBIT;
                end
            end
            // Start bit goes low in the last inhibit cycle so data is already down when the clock lets go.
            INHIBIT: begin
                cntNxt = cnt + 1'b1;
                if (cnt == CW'(INHIBIT_CYCLES - 2))
                    dataOeNxt = 1'b1;
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    clkOeNxt = 1'b0;
                    cntNxt   = '0;
                    stateNxt = SEND;
                end
            end
            SEND: begin
                if (clkFall) begin
                    if (bitCnt == 4'd9) begin
                        dataOeNxt = 1'b0;
                        stateNxt  = ACK;
                    end else begin
                        dataOeNxt = ~frame[bitCnt];
                        bitCntNxt = bitCnt + 4'd1;
                    end
                end
            end
            ACK: begin
                if (clkFall) begin
                    if (dataSync) begin
                        errNxt   = 1'b1;
                        stateNxt = IDLE;
                    end else begin
                        stateNxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clkSync && dataSync) begin
                    doneNxt  = 1'b1;
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (state == SEND || state == ACK || state == WAIT_IDLE) begin
            cntNxt = cnt + 1'b1;
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                errNxt    = 1'b1;
                doneNxt   = 1'b0;
                clkOeNxt  = 1'b0;
                dataOeNxt = 1'b0;
                stateNxt  = IDLE;
            end
        end
`endif
    end

    assign tx_ready    = (state == IDLE);
    assign rx_inhibit  = (state != IDLE);
    assign tx_done     = done;
    assign tx_err      = err;
    assign ps2_clk_oe  = clkOe;
    assign ps2_data_oe = dataOe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple keyboard model (scaled clock rate).
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int TO   = 3000;
    localparam int HALF = 20;   // device clock half-period in board clocks

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_done, tx_err;
    logic        ps2_clk_oe, ps2_data_oe, rx_inhibit;
    logic        ps2_clk_in, ps2_data_in;
    logic        devClkLow = 1'b0;
    logic        devDataLow = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int bothCnt = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | devClkLow);
    assign ps2_data_in = ~(ps2_data_oe | devDataLow);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1) doneCnt++;
        if (tx_err === 1'b1) errCnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) bothCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request a byte, time the inhibit phase, then clock nFalls bits out of the host.
    task automatic run_frame(input logic [7:0] d, input int nFalls, input bit ack,
                             output int inh, output int dcnt, output bit dlast,
                             output logic [10:0] cap);
        cap = '0; inh = 0; dcnt = 0; dlast = 1'b0;
        @(posedge clk); #1 tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0;
        while (ps2_clk_oe === 1'b1 && inh < 20000) begin
            inh++;
            dcnt += int'(ps2_data_oe);
            dlast = ps2_data_oe;
            @(posedge clk); #1;
        end
        cap[0] = ps2_data_in;
        for (int k = 1; k <= nFalls; k++) begin
            if (k == 11 && ack) devDataLow = 1'b1;
            repeat (HALF) @(posedge clk);
            #1 devClkLow = 1'b1;
            repeat (HALF) @(posedge clk);
            #1 devClkLow = 1'b0;
            if (k <= 10) cap[k] = ps2_data_in;
        end
        if (nFalls == 11) begin
            repeat (HALF) @(posedge clk);
            #1 devDataLow = 1'b0;
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n;
        n = 0;
        while (doneCnt == d0 && errCnt == e0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int inh, dcnt, d0, e0, cyc;
        bit dlast;
        logic [10:0] cap;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done_err", 32'({tx_done, tx_err}), 32'd0);
        check("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 0xED with ACK, also timing the inhibit window
        d0 = doneCnt; e0 = errCnt;
        run_frame(8'hED, 11, 1'b1, inh, dcnt, dlast, cap);
        check("inh_clk_cycles", 32'(inh), 32'd5000);
        check("inh_data_cycles", 32'(dcnt), 32'd1);
        check("inh_data_last", 32'(dlast), 32'd1);
        check("ed_bits", 32'(cap), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        wait_end(d0, e0);
        check("ed_done", 32'(doneCnt - d0), 32'd1);
        check("ed_no_err", 32'(errCnt - e0), 32'd0);
        check("ed_ready", 32'(tx_ready), 32'd1);

        // parity extremes
        d0 = doneCnt; e0 = errCnt;
        run_frame(8'h00, 11, 1'b1, inh, dcnt, dlast, cap);
        check("p00_bits", 32'(cap), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
        wait_end(d0, e0);
        check("p00_done", 32'(doneCnt - d0), 32'd1);
        d0 = doneCnt; e0 = errCnt;
        run_frame(8'h01, 11, 1'b1, inh, dcnt, dlast, cap);
        check("p01_bits", 32'(cap), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
        wait_end(d0, e0);
        check("p01_done", 32'(doneCnt - d0), 32'd1);

        // NACK on 0xFF
        d0 = doneCnt; e0 = errCnt;
        run_frame(8'hFF, 11, 1'b0, inh, dcnt, dlast, cap);
        check("ff_bits", 32'(cap), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
        wait_end(d0, e0);
        check("nack_err", 32'(errCnt - e0), 32'd1);
        check("nack_no_done", 32'(doneCnt - d0), 32'd0);
        check("nack_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("nack_ready", 32'(tx_ready), 32'd1);

        // reset mid-frame of 0xF4 with the bit counter at 4 (d3=0 on the line)
        run_frame(8'hF4, 4, 1'b0, inh, dcnt, dlast, cap);
        check("f4_bits", 32'(cap[4:0]), 32'h08);
        check("f4_busy", 32'({tx_ready, rx_inhibit, ps2_data_oe}), 32'h3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        d0 = doneCnt; e0 = errCnt;
        run_frame(8'hED, 11, 1'b1, inh, dcnt, dlast, cap);
        check("post_rst_bits", 32'(cap), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        wait_end(d0, e0);
        check("post_rst_done", 32'(doneCnt - d0), 32'd1);

        // silent device
        d0 = doneCnt; e0 = errCnt;
        run_frame(8'hEE, 0, 1'b0, inh, dcnt, dlast, cap);
`ifdef PS2_TX_TIMEOUT_EN
        cyc = 0;
        while (tx_err !== 1'b1 && cyc < 2 * TO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TO));
        @(posedge clk); #1;
        check("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_err_cnt", 32'(errCnt - e0), 32'd1);
`else
        cyc = 0;
        repeat (2 * TO) @(posedge clk);
        #1;
        check("silent_busy", 32'({tx_ready, rx_inhibit}), 32'h1);
        check("silent_no_err", 32'(errCnt - e0), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("silent_rst_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
`endif
        check("silent_no_done", 32'(doneCnt - d0), 32'd0);
        check("never_both", 32'(bothCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
